// File: rtl/block_pkg.sv
// ============================================================================
// Module      : block_pkg
// Description : Shared types and constants for the block scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package block_pkg;

    typedef struct packed {
        logic [17:0] spawn_time;
        logic [11:0] x;
        logic [11:0] y;
        logic        color;
        logic [2:0]  direction;
    } block_rec_t;

    localparam int         Z_VIS_MAX    = 3000;
    localparam logic [1:0] GAME_PLAYING = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_DRAIN  = 2'd2,
        S_COMMIT = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/block_z_calc.sv
// ============================================================================
// Module      : block_z_calc
// Description : One-stage pipeline computing delta, z and visibility per record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_z_calc
    import block_pkg::*;
#(
    parameter int Z_PER_TICK = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               i_valid,
    input  block_rec_t         i_rec,
    input  logic [7:0]         i_idx,
    input  logic [17:0]        i_time,
    output logic               o_valid,
    output logic               o_visible,
    output logic signed [13:0] o_z,
    output block_rec_t         o_rec,
    output logic [7:0]         o_idx
);

    logic signed [18:0] w_delta;
    logic signed [51:0] w_prod;
    logic               w_in_range;

    // Wide product so a far-future spawn can never wrap into the visible range
    assign w_delta    = $signed({1'b0, i_rec.spawn_time}) - $signed({1'b0, i_time});
    assign w_prod     = 52'(w_delta) * 52'(Z_PER_TICK);
    assign w_in_range = (w_prod <= 52'(Z_VIS_MAX));

    logic               r_valid;
    logic signed [18:0] r_delta;
    logic signed [13:0] r_z;
    logic               r_in_range;
    block_rec_t         r_rec;
    logic [7:0]         r_idx;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_valid    <= 1'b0;
            r_delta    <= '0;
            r_z        <= '0;
            r_in_range <= 1'b0;
            r_rec      <= '0;
            r_idx      <= '0;
        end else begin
            r_valid    <= i_valid;
            r_delta    <= w_delta;
            r_z        <= w_prod[13:0];
            r_in_range <= w_in_range;
            r_rec      <= i_rec;
            r_idx      <= i_idx;
        end
    end

    assign o_valid   = r_valid;
    assign o_visible = r_in_range & ~r_delta[18];
    assign o_z       = r_z;
    assign o_rec     = r_rec;
    assign o_idx     = r_idx;

endmodule

`default_nettype wire

// File: rtl/block_scheduler.sv
// ============================================================================
// Module      : block_scheduler
// Description : Scans the block table each frame and commits the nearest
//               visible block. Optional BLOCK_SCHED_COUNT_EN adds a count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_scheduler
    import block_pkg::*;
#(
    parameter int Z_PER_TICK  = 4,
    parameter int MAX_BLOCKS  = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               new_frame_in,
    input  logic [1:0]         state,
    input  logic [17:0]        curr_time,
    input  logic [8:0]         num_blocks_in,
    output logic [7:0]         mem_addr_out,
    input  logic [45:0]        mem_data_in,
    output logic               block_visible,
    output logic [7:0]         curr_block_index_out,
    output logic [11:0]        block_x,
    output logic [11:0]        block_y,
    output logic signed [13:0] block_z,
    output logic               block_color,
    output logic [2:0]         block_direction,
    output logic               busy_out,
    output logic               scan_done_out
`ifdef BLOCK_SCHED_COUNT_EN
    ,
    output logic [8:0]         visible_count_out
`endif
);

    localparam logic [8:0] c_MAX_N      = 9'(MAX_BLOCKS);
    localparam logic [7:0] c_DRAIN_LAST = 8'(MEM_LATENCY);

    sched_state_t r_state, w_next;
    logic [17:0]  r_time;
    logic [8:0]   r_n;
    logic [8:0]   r_addr;
    logic [7:0]   r_drain;
    logic         r_pending;

    logic         w_go, w_start, w_issue, w_last_issue;
    logic [8:0]   w_n_clamped;

    assign w_go         = (state == GAME_PLAYING) && (num_blocks_in != 9'd0);
    assign w_n_clamped  = (num_blocks_in > c_MAX_N) ? c_MAX_N : num_blocks_in;
    assign w_last_issue = (r_state == S_SCAN) && (r_addr == r_n - 9'd1);

    always_ff @(posedge clk_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (new_frame_in) w_next = w_go ? S_SCAN : S_COMMIT;
            S_SCAN:   if (w_last_issue) w_next = S_DRAIN;
            S_DRAIN:  if (r_drain == c_DRAIN_LAST) w_next = S_COMMIT;
            S_COMMIT: begin
                if (r_pending || new_frame_in) w_next = w_go ? S_SCAN : S_COMMIT;
                else                           w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_out     = (r_state != S_IDLE);
        w_issue      = (r_state == S_SCAN);
        mem_addr_out = w_issue ? r_addr[7:0] : 8'd0;
        w_start      = ((r_state == S_IDLE) && new_frame_in) ||
                       ((r_state == S_COMMIT) && (r_pending || new_frame_in));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_time    <= '0;
            r_n       <= '0;
            r_addr    <= '0;
            r_drain   <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_start) begin
                r_time <= curr_time;
                r_n    <= w_n_clamped;
                r_addr <= '0;
            end else if (w_issue) begin
                r_addr <= r_addr + 9'd1;
            end
            r_drain <= (r_state == S_DRAIN) ? r_drain + 8'd1 : 8'd0;
            if (w_start)                   r_pending <= 1'b0;
            else if (busy_out && new_frame_in) r_pending <= 1'b1;
        end
    end

    // Index travels alongside the read so it lines up with the returning data
    logic [MEM_LATENCY-1:0] r_vld_sr;
    logic [7:0]             r_idx_sr [MEM_LATENCY];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_vld_sr <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) r_idx_sr[i] <= '0;
        end else begin
            r_vld_sr[0] <= w_issue;
            r_idx_sr[0] <= r_addr[7:0];
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
                r_idx_sr[i] <= r_idx_sr[i-1];
            end
        end
    end

    block_rec_t         w_mem_rec;
    logic               w_z_valid, w_z_vis;
    logic signed [13:0] w_z;
    block_rec_t         w_z_rec;
    logic [7:0]         w_z_idx;

    assign w_mem_rec = block_rec_t'(mem_data_in);

    block_z_calc #(
        .Z_PER_TICK (Z_PER_TICK)
    ) u_z_calc (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_valid   (r_vld_sr[MEM_LATENCY-1]),
        .i_rec     (w_mem_rec),
        .i_idx     (r_idx_sr[MEM_LATENCY-1]),
        .i_time    (r_time),
        .o_valid   (w_z_valid),
        .o_visible (w_z_vis),
        .o_z       (w_z),
        .o_rec     (w_z_rec),
        .o_idx     (w_z_idx)
    );

    logic               r_best_vld;
    logic signed [13:0] r_best_z;
    block_rec_t         r_best_rec;
    logic [7:0]         r_best_idx;

    // Strict less-than keeps the earliest index on a z tie
    always_ff @(posedge clk_in) begin
        if (!rst_in || w_start) begin
            r_best_vld <= 1'b0;
            r_best_z   <= '0;
            r_best_rec <= '0;
            r_best_idx <= '0;
        end else if (w_z_valid && w_z_vis && (!r_best_vld || (w_z < r_best_z))) begin
            r_best_vld <= 1'b1;
            r_best_z   <= w_z;
            r_best_rec <= w_z_rec;
            r_best_idx <= w_z_idx;
        end
    end

`ifdef BLOCK_SCHED_COUNT_EN
    logic [8:0] r_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_in || w_start)     r_cnt <= '0;
        else if (w_z_valid && w_z_vis) r_cnt <= r_cnt + 9'd1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in)                  visible_count_out <= '0;
        else if (r_state == S_COMMIT) visible_count_out <= r_cnt;
    end
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            block_visible        <= 1'b0;
            curr_block_index_out <= '0;
            block_x              <= '0;
            block_y              <= '0;
            block_z              <= '0;
            block_color          <= 1'b0;
            block_direction      <= '0;
            scan_done_out        <= 1'b0;
        end else begin
            scan_done_out <= (r_state == S_COMMIT);
            if (r_state == S_COMMIT) begin
                block_visible        <= r_best_vld;
                curr_block_index_out <= r_best_idx;
                block_x              <= r_best_rec.x;
                block_y              <= r_best_rec.y;
                block_z              <= r_best_z;
                block_color          <= r_best_rec.color;
                block_direction      <= r_best_rec.direction;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/block_scheduler.md
BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 SHALL have parameter Z_PER_TICK, default 4: z units per time tick until spawn.
REQ-002 SHALL have parameter MAX_BLOCKS, default 256: block table depth.
REQ-003 SHALL have parameter MEM_LATENCY, default 2: fixed table read latency in cycles.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port new_frame_in, input, 1 bit: one-cycle pulse that starts a scan.
REQ-007 SHALL have port state, input, 2 bits: game state; 2'd1 = PLAYING.
REQ-008 SHALL have port curr_time, input, 18 bits: game time, sampled once at scan start.
REQ-009 SHALL have port num_blocks_in, input, 9 bits: valid table entries, 0..MAX_BLOCKS.
REQ-010 SHALL have port mem_addr_out, output, 8 bits: table read address.
REQ-011 SHALL have port mem_data_in, input, 46 bits: record {spawn_time[17:0], x[11:0], y[11:0], color, direction[2:0]}.
REQ-012 SHALL have ports block_visible (1), curr_block_index_out (8), block_x (12), block_y (12), block_z (14, signed), block_color (1) and block_direction (3), all outputs: the committed block consumed by the renderer.
REQ-013 SHALL have ports busy_out (1) and scan_done_out (1), both outputs.

Function
REQ-014 SHALL be a state machine with states IDLE, SCAN, DRAIN and COMMIT.
REQ-015 IDLE->SCAN SHALL occur on new_frame_in when state==PLAYING and num_blocks_in>0; curr_time and num_blocks_in are latched on that edge.
REQ-016 SCAN SHALL issue addresses 0..N-1 on consecutive cycles, one per cycle.
REQ-017 DRAIN SHALL last until the last record is evaluated; COMMIT SHALL last one cycle and then return to IDLE.
REQ-018 Per record, delta = spawn_time - latched curr_time (signed); z = delta*Z_PER_TICK.
REQ-019 A record SHALL be visible iff delta>=0 and z<=3000; the z computation SHALL NOT wrap, and any product >3000 SHALL count as not visible.
REQ-020 SHALL select the visible record with the smallest z; on equal z the lowest index wins.
REQ-021 Pulse on cycle 0, N>0: output registers SHALL update and scan_done_out pulse exactly on cycle N+MEM_LATENCY+3.
REQ-022 Output registers SHALL hold their previous values throughout a scan, so the renderer never sees a partial result.
REQ-023 No visible record: SHALL commit block_visible=0; the other block outputs are 0.
REQ-024 new_frame_in with state!=PLAYING or num_blocks_in==0 SHALL skip SCAN; commit block_visible=0 and pulse scan_done_out on cycle 2.
REQ-025 new_frame_in while busy SHALL set a one-deep pending flag; further pulses are absorbed; the pending scan starts the cycle after COMMIT.
REQ-026 busy_out SHALL be high in SCAN, DRAIN and COMMIT.
REQ-027 num_blocks_in>MAX_BLOCKS SHALL be clamped to MAX_BLOCKS.

Reset
REQ-028 While rst_in==0, SHALL enter IDLE and clear the pending flag.
REQ-029 While rst_in==0, all outputs SHALL be 0, including mem_addr_out, busy_out and scan_done_out.
REQ-030 Reset mid-scan SHALL abort the scan with no commit, and SHALL discard read data still in flight.

Configuration
REQ-031 With BLOCK_SCHED_COUNT_EN defined: SHALL provide output visible_count_out (9 bits), the number of visible records, updated at COMMIT and reset to 0.
REQ-032 Without BLOCK_SCHED_COUNT_EN: the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package block_pkg SHALL hold block_rec_t (46-bit packed struct), constant Z_VIS_MAX=3000, constant GAME_PLAYING=2'd1 and the scheduler state enum.
REQ-034 Sub-module block_z_calc SHALL register delta, z and the visible flag, giving one pipeline stage.

Verification
REQ-035 Reset then idle: all outputs 0 and busy_out=0 for 100 cycles.
REQ-036 N=3, curr_time=100, spawns {110,105,90}, Z_PER_TICK=4: expect index 1, z=20, visible=1, done on cycle 8.
REQ-037 Spawns {850,1000} at curr_time=100: z=3000 is visible and z=3600 is not; expect index 0, z=3000.
REQ-038 Two records with equal spawn=120 at indices 4 and 7: expect index 4.
REQ-039 state=2'd0 with a pulse: done on cycle 2 with visible=0; second pulse during a 256-block scan: exactly one extra scan follows.
REQ-040 rst_in low at scan cycle 50, then a new scan: no stale commit; the result matches a clean scan.
